// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmit datapath with byte FIFO and programmable bit period
//
// Purpose: buffers THR bytes in a DEPTH-entry FIFO and shifts each one out
// as start bit, 8 data bits LSB first, stop bit, div_q clk cycles per bit.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   wr_valid  byte offered by the register block
//   wr_data   byte to transmit
//   wr_ready  FIFO has room (count < DEPTH)
//   divisor   clk cycles per bit, 0 treated as 1, sampled when a frame starts
//   tx        serial line, idle high, registered
//   thre      FIFO empty
//   temt      FIFO empty and serialiser idle
module uart_tx #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic [DIV_W-1:0] divisor,
  output logic             tx,
  output logic             thre,
  output logic             temt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic [1:0]       state;
  logic [2:0]       bit_idx;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       shift;

  logic             do_wr;
  logic             do_pop;
  logic             bit_end;
  logic [DIV_W-1:0] div_eff;

  // wr_ready looks only at count, so a full FIFO stays not-ready even in a
  // cycle where a pop is about to free an entry.
  assign wr_ready = (count < DEPTH_CNT);
  assign do_wr    = wr_valid & wr_ready;
  assign do_pop   = (state == S_IDLE) && (count != '0);
  assign bit_end  = (baud_cnt == '0);
  assign div_eff  = (divisor == '0) ? DIV_W'(1) : divisor;

  assign thre = (count == '0);
  assign temt = thre && (state == S_IDLE);

  // Storage is not reset: entries are only readable once written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_idx  <= '0;
      baud_cnt <= '0;
      div_q    <= DIV_W'(1);
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (do_pop) begin
            shift    <= mem[rd_ptr];
            div_q    <= div_eff;
            baud_cnt <= div_eff - DIV_W'(1);
            state    <= S_START;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= div_q - DIV_W'(1);
            bit_idx  <= '0;
            state    <= S_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= div_q - DIV_W'(1);
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              // shift[1] is the bit that becomes shift[0] on this edge.
              tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: begin
          if (bit_end) begin
            baud_cnt <= div_q - DIV_W'(1);
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
          tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

  localparam int NH = 8192;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [15:0] divisor;
  logic        tx;
  logic        thre;
  logic        temt;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  logic hist [0:NH-1];

  uart_tx #(.DEPTH(16), .DIV_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .divisor  (divisor),
    .tx       (tx),
    .thre     (thre),
    .temt     (temt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line log: hist[c] is the tx level during cycle c.
  always @(negedge clk) begin
    if (ncyc < NH) hist[ncyc] = tx;
    ncyc = ncyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer a byte, wait for acceptance; acc is the cycle right after the accepting edge.
  task automatic push(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("push_timeout", 32'(n), 32'd0);
    tick();
    wr_valid = 1'b0;
    acc = ncyc;
  endtask

  // Expected line for one frame: 10 symbols {start 0, data LSB first, stop 1}, d cycles each.
  task automatic check_frame(input string tag, input int s, input int d, input logic [7:0] b);
    logic [9:0] sym;
    logic [7:0] got;
    int bad;
    sym = {1'b1, b, 1'b0};
    bad = 0;
    for (int k = 0; k < 10 * d; k++) begin
      if (s + k >= NH || hist[s + k] !== sym[k / d]) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      got[i] = hist[s + (i + 1) * d + d / 2];
    end
    check({tag, "_idle_before"}, 32'(hist[s - 1]), 32'd1);
    check({tag, "_levels"}, 32'(bad), 32'd0);
    check({tag, "_byte"}, 32'(got), 32'(b));
  endtask

  initial begin
    int a, s, s0, d, n, r, zeros;
    logic [7:0] bytes [6];

    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h5a;
    divisor  = 16'd4;

    // Reset held with a write offered
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_thre", 32'(thre), 32'd1);
    check("rst_temt", 32'(temt), 32'd1);
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    repeat (5) tick();
    check("rst_no_enqueue_thre", 32'(thre), 32'd1);
    check("rst_no_enqueue_tx", 32'(tx), 32'd1);

    // Single byte 0x55, divisor 4: latency and exact waveform
    divisor = 16'd4;
    push(8'h55, a);
    check("lat_tx_pop_cycle", 32'(tx), 32'd1);
    check("lat_thre_low", 32'(thre), 32'd0);
    check("lat_temt_low", 32'(temt), 32'd0);
    tick();
    check("lat_tx_falls", 32'(tx), 32'd0);
    repeat (38) tick();
    check("single_temt_last_stop", 32'(temt), 32'd0);
    repeat (3) tick();
    check("single_temt_end", 32'(temt), 32'd1);
    check_frame("single55", a + 1, 4, 8'h55);

    // Divisor 0 behaves as 1, then divisor 1
    divisor = 16'd0;
    push(8'ha3, a);
    repeat (14) tick();
    check_frame("div0", a + 1, 1, 8'ha3);
    divisor = 16'd1;
    push(8'ha3, a);
    repeat (14) tick();
    check_frame("div1", a + 1, 1, 8'ha3);

    // Full FIFO at divisor 8, plus one byte held off until the next pop
    divisor = 16'd8;
    s0 = 0;
    for (int i = 0; i <= 16; i++) begin
      push(8'(i), a);
      if (i == 0) s0 = a + 1;
    end
    check("full_ready_low", 32'(wr_ready), 32'd0);
    wr_data  = 8'h11;
    wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 300) begin
      tick();
      n++;
    end
    check("full_ready_rise_cycle", 32'(ncyc), 32'(s0 + 81));
    tick();
    wr_valid = 1'b0;
    repeat (18 * 81) tick();
    check("full_drained_temt", 32'(temt), 32'd1);
    for (int i = 0; i <= 17; i++) begin
      check_frame($sformatf("full%0d", i), s0 + i * 81, 8, 8'(i));
    end

    // Divisor change during DATA applies only to the next frame
    divisor = 16'd4;
    bytes[0] = 8'($urandom);
    push(8'hff, a);
    push(bytes[0], n);
    s = a + 1;
    while (ncyc < s + 10) tick();
    divisor = 16'd2;
    repeat (70) tick();
    check_frame("divchg_first", s, 4, 8'hff);
    check_frame("divchg_second", s + 41, 2, bytes[0]);

    // Randomized bursts with random divisors
    for (int t = 0; t < 3; t++) begin
      d = $urandom_range(1, 5);
      divisor = 16'(d);
      for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
        push(bytes[i], a);
        if (i == 0) s = a + 1;
      end
      repeat (6 * (10 * d + 1) + 5) tick();
      for (int i = 0; i < 6; i++) begin
        check_frame($sformatf("rnd%0d_%0d", t, i), s + i * (10 * d + 1), d, bytes[i]);
      end
    end

    // Reset during data bit 3 with 5 bytes queued
    divisor = 16'd4;
    push(8'h00, a);
    for (int i = 0; i < 5; i++) push(8'($urandom), n);
    s = a + 1;
    while (ncyc < s + 4 * 4 + 1) tick();
    check("midrst_tx_before", 32'(tx), 32'd0);
    rst_n = 1'b0;
    tick();
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_thre", 32'(thre), 32'd1);
    check("midrst_temt", 32'(temt), 32'd1);
    check("midrst_wr_ready", 32'(wr_ready), 32'd1);
    r = ncyc;
    rst_n = 1'b1;
    repeat (80) tick();
    zeros = 0;
    for (int c = r; c < ncyc; c++) if (hist[c] !== 1'b1) zeros++;
    check("midrst_no_frames", 32'(zeros), 32'd0);
    check("midrst_thre_after", 32'(thre), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
